// File: rtl/data_sram_resp.sv
// data_sram_resp
//
// Single-port 32-bit word SRAM behind a request/response handshake.
// A request is accepted in the cycle req=1 and addr_ok=1. Writes update the
// RAM immediately (byte-masked by wstrb). Reads capture the RAM word in the
// acceptance cycle. Every accepted request, read or write, gets exactly one
// data_ok pulse LAT cycles later. Responses are returned strictly in
// acceptance order, one per cycle, from a QDEPTH-deep pending FIFO.
//
// Ports
//   clk      in   1   clock, rising edge
//   reset    in   1   synchronous, active-high
//   req      in   1   request valid
//   wr       in   1   1 = write, 0 = read
//   wstrb    in   4   byte enables (writes only)
//   addr     in  32   byte address; word index is addr[ADDR_W+1:2]
//   wdata    in  32   write data
//   addr_ok  out  1   request can be accepted this cycle
//   data_ok  out  1   response pulse
//   rdata    out 32   read data while data_ok=1 (zero for writes / idle)
module data_sram_resp #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int          PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CNT_W = PTR_W + 1;
    localparam int          WORDS = 1 << ADDR_W;
    localparam logic [2:0]  LAT_C = 3'(LAT);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_word[b*8 +: 8] : old_word[b*8 +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem [0:WORDS-1];

    // Pending-response FIFO. Writes store zero as their response data, so no
    // separate read/write flag is needed per entry.
    logic [31:0]      q_data_p1 [0:QDEPTH-1];
    logic [2:0]       q_age_p1  [0:QDEPTH-1];
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [CNT_W-1:0] count_p1;

    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       ram_word;
    logic              accept_p0;
    logic              pop_p0;
    logic              unused_addr;

    assign word_idx    = addr[ADDR_W+1:2];
    assign ram_word    = mem[word_idx];
    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    // Stage 0: handshake and response selection, all from registered state.
    assign addr_ok   = !reset && (count_p1 < DEPTH_C);
    assign accept_p0 = req && addr_ok;
    assign data_ok   = !reset && (count_p1 != '0) && (q_age_p1[head_p1] == LAT_C);
    assign pop_p0    = data_ok;
    assign rdata     = data_ok ? q_data_p1[head_p1] : 32'h0;

    // RAM is never touched by reset; only accepted writes modify it.
    always_ff @(posedge clk) begin
        if (accept_p0 && wr) begin
            mem[word_idx] <= merge_bytes(ram_word, wdata, wstrb);
        end
    end

    // Stage 1: FIFO entry data (no reset on data).
    always_ff @(posedge clk) begin
        if (accept_p0) begin
            q_data_p1[tail_p1] <= wr ? 32'h0 : ram_word;
        end
    end

    // Age counters: a new entry starts at 1 so that it reaches LAT exactly
    // LAT cycles after acceptance; counters saturate at LAT.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (reset) begin
                q_age_p1[i] <= 3'd0;
            end else if (accept_p0 && (tail_p1 == PTR_W'(i))) begin
                q_age_p1[i] <= 3'd1;
            end else if (q_age_p1[i] < LAT_C) begin
                q_age_p1[i] <= q_age_p1[i] + 3'd1;
            end
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_p1  <= '0;
            tail_p1  <= '0;
            count_p1 <= '0;
        end else begin
            if (accept_p0) begin
                tail_p1 <= tail_p1 + PTR_W'(1);
            end
            if (pop_p0) begin
                head_p1 <= head_p1 + PTR_W'(1);
            end
            case ({accept_p0, pop_p0})
                2'b10:   count_p1 <= count_p1 + CNT_W'(1);
                2'b01:   count_p1 <= count_p1 - CNT_W'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters (LAT=2, QDEPTH=4)
    logic        reset_a, req_a, wr_a;
    logic [3:0]  wstrb_a;
    logic [31:0] addr_a, wdata_a;
    logic        addr_ok_a, data_ok_a;
    logic [31:0] rdata_a;

    // DUT B: LAT=6, QDEPTH=4 for back-pressure
    logic        reset_b, req_b, wr_b;
    logic [3:0]  wstrb_b;
    logic [31:0] addr_b, wdata_b;
    logic        addr_ok_b, data_ok_b;
    logic [31:0] rdata_b;

    data_sram_resp dut_a (
        .clk(clk), .reset(reset_a), .req(req_a), .wr(wr_a), .wstrb(wstrb_a),
        .addr(addr_a), .wdata(wdata_a), .addr_ok(addr_ok_a),
        .data_ok(data_ok_a), .rdata(rdata_a)
    );

    data_sram_resp #(.ADDR_W(10), .LAT(6), .QDEPTH(4)) dut_b (
        .clk(clk), .reset(reset_b), .req(req_b), .wr(wr_b), .wstrb(wstrb_b),
        .addr(addr_b), .wdata(wdata_b), .addr_ok(addr_ok_b),
        .data_ok(data_ok_b), .rdata(rdata_b)
    );

    typedef struct {
        logic        req;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model state for DUT B
    int          b_cyc = 0;
    int          b_tq[$];
    logic [31:0] b_dq[$];
    logic [31:0] b_mem [0:1023];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step_a(input vec_t v, input string nm);
        req_a = v.req; wr_a = v.wr; wstrb_a = v.wstrb; addr_a = v.addr; wdata_a = v.wdata;
        @(negedge clk);
        check({nm, " addr_ok"}, 32'(addr_ok_a), 32'(v.aok));
        check({nm, " data_ok"}, 32'(data_ok_a), 32'(v.dok));
        check({nm, " rdata"}, rdata_a, v.rd);
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic acc,
                          output logic s_aok, output logic s_dok);
        logic        m_aok, m_dok;
        logic [31:0] m_rd;
        req_b = r; wr_b = w; wstrb_b = 4'hF; addr_b = a; wdata_b = d;
        @(negedge clk);
        m_aok = (b_tq.size() < 4);
        m_dok = (b_tq.size() > 0) && (b_cyc >= b_tq[0] + 6);
        m_rd  = m_dok ? b_dq[0] : 32'h0;
        check($sformatf("b cyc%0d addr_ok", b_cyc), 32'(addr_ok_b), 32'(m_aok));
        check($sformatf("b cyc%0d data_ok", b_cyc), 32'(data_ok_b), 32'(m_dok));
        check($sformatf("b cyc%0d rdata", b_cyc), rdata_b, m_rd);
        s_aok = addr_ok_b;
        s_dok = data_ok_b;
        acc = r && m_aok;
        if (m_dok) begin
            void'(b_tq.pop_front());
            void'(b_dq.pop_front());
        end
        if (acc) begin
            b_tq.push_back(b_cyc);
            b_dq.push_back(w ? 32'h0 : b_mem[a[11:2]]);
            if (w) b_mem[a[11:2]] = d;
        end
        b_cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [0:32];
        vec_t idle;
        logic acc, s_aok, s_dok;

        idle = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};

        tbl[0]  = idle;
        tbl[1]  = '{1'b1, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 4'h0, 32'h10,       32'h0,        1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b1, 4'hF, 32'h20,       32'h11223344, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 4'h2, 32'h20,       32'h0000AA00, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        1'b1, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h1122AA44};
        tbl[10] = '{1'b1, 1'b0, 4'h0, 32'hFFFFF010, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[11] = idle;
        tbl[12] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hDEADBEEF};
        tbl[13] = '{1'b1, 1'b1, 4'hF, 32'h0,        32'hA0A0A0A0, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b1, 4'hF, 32'h4,        32'hB1B1B1B1, 1'b1, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b1, 4'hF, 32'h8,        32'hC2C2C2C2, 1'b1, 1'b1, 32'h0};
        tbl[16] = '{1'b1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[17] = '{1'b1, 1'b0, 4'h0, 32'h4,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[18] = '{1'b1, 1'b0, 4'h0, 32'h8,        32'h0,        1'b1, 1'b1, 32'hA0A0A0A0};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hB1B1B1B1};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hC2C2C2C2};
        tbl[21] = idle;
        tbl[22] = '{1'b1, 1'b0, 4'hF, 32'h0,        32'h55555555, 1'b1, 1'b0, 32'h0};
        tbl[23] = '{1'b0, 1'b1, 4'hF, 32'h4,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        tbl[24] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hA0A0A0A0};
        tbl[25] = '{1'b1, 1'b1, 4'h0, 32'h4,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
        tbl[26] = '{1'b1, 1'b0, 4'h0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h0};
        tbl[27] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[28] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'hB1B1B1B1};
        tbl[29] = '{1'b1, 1'b1, 4'h9, 32'h8,        32'h11FFFF22, 1'b1, 1'b0, 32'h0};
        tbl[30] = '{1'b1, 1'b0, 4'h0, 32'h8,        32'h0,        1'b1, 1'b0, 32'h0};
        tbl[31] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0};
        tbl[32] = '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h11C2C222};

        reset_a = 1'b1; req_a = 1'b0; wr_a = 1'b0; wstrb_a = 4'h0; addr_a = 32'h0; wdata_a = 32'h0;
        reset_b = 1'b1; req_b = 1'b0; wr_b = 1'b0; wstrb_b = 4'h0; addr_b = 32'h0; wdata_b = 32'h0;

        // Outputs while reset is held, with a request pending on the inputs
        @(posedge clk); #1;
        req_a = 1'b1; req_b = 1'b1;
        @(negedge clk);
        check("reset a addr_ok", 32'(addr_ok_a), 32'h0);
        check("reset a data_ok", 32'(data_ok_a), 32'h0);
        check("reset a rdata",   rdata_a,        32'h0);
        check("reset b addr_ok", 32'(addr_ok_b), 32'h0);
        check("reset b data_ok", 32'(data_ok_b), 32'h0);
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        reset_a = 1'b0; reset_b = 1'b0;

        // Table-driven vectors on DUT A
        for (int i = 0; i < 33; i++) begin
            step_a(tbl[i], $sformatf("row%0d", i));
        end

        // Reset pulse with two reads outstanding
        step_a('{1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0}, "rst rd0");
        step_a('{1'b1, 1'b0, 4'h0, 32'h4, 32'h0, 1'b1, 1'b0, 32'h0}, "rst rd1");
        reset_a = 1'b1;
        step_a('{1'b1, 1'b1, 4'hF, 32'h8, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0}, "rst pulse");
        reset_a = 1'b0;
        step_a(idle, "rst after1");
        step_a(idle, "rst after2");
        step_a(idle, "rst after3");
        step_a('{1'b1, 1'b0, 4'h0, 32'h8,  32'h0, 1'b1, 1'b0, 32'h0}, "post rd8");
        step_a('{1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0}, "post rd10");
        step_a('{1'b0, 1'b0, 4'h0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h11C2C222}, "post dok8");
        step_a('{1'b0, 1'b0, 4'h0, 32'h0,  32'h0, 1'b1, 1'b1, 32'hDEADBEEF}, "post dok10");
        step_a(idle, "post idle");

        // DUT B: preload words 0..7, holding req until each write is taken
        for (int i = 0; i < 8; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                step_b(1'b1, 1'b1, 32'(i * 4), 32'h600D0000 + 32'(i), acc, s_aok, s_dok);
            end
            if (!acc) begin
                errors++;
                $display("FAIL b preload%0d: got no accept expected accept", i);
            end
        end
        for (int t = 0; t < 20 && b_tq.size() > 0; t++) begin
            step_b(1'b0, 1'b0, 32'h0, 32'h0, acc, s_aok, s_dok);
        end

        // DUT B: reads with req held until 8 accepted; observe back-pressure
        begin
            int n_acc = 0, n_dok = 0, cyc = 0;
            int acc_at_drop = -1, first_dok = -1, rise_cyc = -1;
            logic seen_drop = 1'b0;
            while (cyc < 200 && n_dok < 8) begin
                step_b(n_acc < 8, 1'b0, 32'(n_acc * 4), 32'h0, acc, s_aok, s_dok);
                if (!s_aok && !seen_drop) begin
                    seen_drop = 1'b1;
                    acc_at_drop = n_acc;
                end
                if (s_aok && seen_drop && rise_cyc < 0) rise_cyc = cyc;
                if (s_dok) begin
                    if (first_dok < 0) first_dok = cyc;
                    n_dok++;
                end
                if (acc) n_acc++;
                cyc++;
            end
            check("b accepts before addr_ok drop", 32'(acc_at_drop), 32'd4);
            check("b addr_ok rise after first data_ok", 32'(rise_cyc), 32'(first_dok + 1));
            check("b response count", 32'(n_dok), 32'd8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
